// File: rtl/guess_number_core.sv
// Bulls-and-cows game engine: tick-sampled buttons, LFSR answer generation, A/B scoring.
// Optional macro GUESS_NUMBER_PEEK_EN adds the answer output and the force_ans input.
module guess_number_core #(
  parameter int          DIGITS    = 4,
  parameter int          MAX_TRIES = 10,
  parameter int          TICK_DIV  = 6250000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                plus,
  input  logic                subtract,
  input  logic                sure,
`ifdef GUESS_NUMBER_PEEK_EN
  input  logic                force_ans,
  output logic [4*DIGITS-1:0] answer,
`endif
  output logic [4*DIGITS-1:0] guess,
  output logic [2:0]          cursor,
  output logic [3:0]          score_a,
  output logic [3:0]          score_b,
  output logic [7:0]          tries,
  output logic [2:0]          state
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GEN   = 3'd1,
    S_EDIT  = 3'd2,
    S_CHECK = 3'd3,
    S_WIN   = 3'd4,
    S_LOSE  = 3'd5
  } state_t;

  localparam int CW = $clog2(TICK_DIV);

  state_t                  state_q, state_d;
  logic [DIGITS-1:0][3:0]  guess_q, guess_d;
  logic [DIGITS-1:0][3:0]  answer_q, answer_d;
  logic [2:0]              cursor_q, cursor_d;
  logic [3:0]              score_a_q, score_a_d, score_b_q, score_b_d;
  logic [7:0]              tries_q, tries_d;
  logic [CW-1:0]           tick_cnt_q, tick_cnt_d;
  logic [15:0]             lfsr_q, lfsr_d;
  logic [2:0]              btn_q, btn_d;
  logic [15:0]             used_q, used_d;
  logic [2:0]              gen_cnt_q, gen_cnt_d;

  logic       tick, p_sure, p_plus, p_sub, hit, start_gen, enter_edit;
  logic [2:0] btn_now, press;
  logic [3:0] cand, a_cnt, b_cnt;

  function automatic logic [DIGITS-1:0][3:0] init_pattern();
    logic [DIGITS-1:0][3:0] p;
    for (int i = 0; i < DIGITS; i++) p[i] = 4'((i + 1) % 10);
    return p;
  endfunction

  // Buttons are active low; a press is a falling sample between consecutive ticks.
  assign btn_now    = {sure, plus, subtract};
  assign tick       = (tick_cnt_q == CW'(TICK_DIV - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + CW'(1);
  assign btn_d      = tick ? btn_now : btn_q;
  assign press      = btn_q & ~btn_now & {3{tick}};
  assign p_sure     = press[2];
  assign p_plus     = press[1] & ~press[0];
  assign p_sub      = press[0] & ~press[1];
  assign lfsr_d     = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign cand       = lfsr_q[3:0];

  always_comb begin
    a_cnt = '0;
    b_cnt = '0;
    hit   = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      hit = 1'b0;
      if (guess_q[i] == answer_q[i]) a_cnt = a_cnt + 4'd1;
      for (int j = 0; j < DIGITS; j++)
        if (j != i && guess_q[i] == answer_q[j]) hit = 1'b1;
      if (hit) b_cnt = b_cnt + 4'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    guess_d    = guess_q;
    answer_d   = answer_q;
    cursor_d   = cursor_q;
    score_a_d  = score_a_q;
    score_b_d  = score_b_q;
    tries_d    = tries_q;
    used_d     = used_q;
    gen_cnt_d  = gen_cnt_q;
    start_gen  = 1'b0;
    enter_edit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (p_sure) start_gen = 1'b1;
`ifdef GUESS_NUMBER_PEEK_EN
        if (force_ans) begin
          start_gen  = 1'b0;
          enter_edit = 1'b1;
          answer_d   = init_pattern();
        end
`endif
      end
      S_GEN: begin
        if (cand <= 4'd9 && !used_q[cand]) begin
          used_d[cand] = 1'b1;
          for (int i = 0; i < DIGITS; i++)
            if (gen_cnt_q == 3'(i)) answer_d[i] = cand;
          if (gen_cnt_q == 3'(DIGITS - 1)) enter_edit = 1'b1;
          else gen_cnt_d = gen_cnt_q + 3'd1;
        end
      end
      S_EDIT: begin
        if (p_sure) begin
          if (cursor_q == 3'(DIGITS - 1)) begin
            cursor_d = '0;
            state_d  = S_CHECK;
          end else begin
            cursor_d = cursor_q + 3'd1;
          end
        end else begin
          for (int i = 0; i < DIGITS; i++) begin
            if (cursor_q == 3'(i)) begin
              if (p_plus)     guess_d[i] = (guess_q[i] == 4'd9) ? 4'd0 : guess_q[i] + 4'd1;
              else if (p_sub) guess_d[i] = (guess_q[i] == 4'd0) ? 4'd9 : guess_q[i] - 4'd1;
            end
          end
        end
      end
      S_CHECK: begin
        score_a_d = a_cnt;
        score_b_d = b_cnt;
        tries_d   = tries_q + 8'd1;
        if (a_cnt == 4'(DIGITS))             state_d = S_WIN;
        else if (tries_d == 8'(MAX_TRIES))   state_d = S_LOSE;
        else                                 state_d = S_EDIT;
      end
      S_WIN, S_LOSE: begin
        if (p_sure) start_gen = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (start_gen) begin
      state_d   = S_GEN;
      used_d    = '0;
      gen_cnt_d = '0;
    end
    if (enter_edit) begin
      state_d   = S_EDIT;
      cursor_d  = '0;
      tries_d   = '0;
      score_a_d = '0;
      score_b_d = '0;
      guess_d   = init_pattern();
    end
  end

  // Button history loads the live levels in reset so a button held through reset is not a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      guess_q    <= init_pattern();
      cursor_q   <= '0;
      score_a_q  <= '0;
      score_b_q  <= '0;
      tries_q    <= '0;
      tick_cnt_q <= '0;
      lfsr_q     <= LFSR_SEED;
      btn_q      <= btn_now;
      used_q     <= '0;
      gen_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      guess_q    <= guess_d;
      cursor_q   <= cursor_d;
      score_a_q  <= score_a_d;
      score_b_q  <= score_b_d;
      tries_q    <= tries_d;
      tick_cnt_q <= tick_cnt_d;
      lfsr_q     <= lfsr_d;
      btn_q      <= btn_d;
      used_q     <= used_d;
      gen_cnt_q  <= gen_cnt_d;
    end
  end

  always_ff @(posedge clk) answer_q <= answer_d;

  always_comb begin
    guess = '0;
    for (int i = 0; i < DIGITS; i++) guess[4*(DIGITS-i)-1 -: 4] = guess_q[i];
  end

`ifdef GUESS_NUMBER_PEEK_EN
  always_comb begin
    answer = '0;
    for (int i = 0; i < DIGITS; i++) answer[4*(DIGITS-i)-1 -: 4] = answer_q[i];
  end
`endif

  assign cursor  = cursor_q;
  assign score_a = score_a_q;
  assign score_b = score_b_q;
  assign tries   = tries_q;
  assign state   = state_q;
endmodule

// File: tb/tb_guess_number_core.sv
// Bench for guess_number_core: two instances (MAX_TRIES 10 and 2), TICK_DIV=4, DIGITS=4.
// Honours GUESS_NUMBER_PEEK_EN when the design is built with it.
module tb_guess_number_core;
  localparam int          TICK = 4;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [2:0]  S_IDLE = 3'd0, S_GEN = 3'd1, S_EDIT = 3'd2, S_WIN = 3'd4, S_LOSE = 3'd5;
  localparam int          B_SURE = 0, B_PLUS = 1, B_SUB = 2, B_BOTH = 3;

  logic       clk;
  logic [1:0] reset_v, plus_n, sub_n, sure_n, force_v;
  logic [15:0] g_o [2];
  logic [15:0] ans_o [2];
  logic [2:0]  cur_o [2];
  logic [3:0]  sa_o [2];
  logic [3:0]  sb_o [2];
  logic [7:0]  tr_o [2];
  logic [2:0]  st [2];

  int          n_checks, n_fail;
  logic [15:0] m_lfsr [2];
  logic [15:0] exp_ans [2];
  logic [15:0] exp_guess [2];
  int          exp_len [2];
  int          gen_cnt [2];
  logic        in_gen [2];

  typedef struct {
    int          k;
    logic [15:0] perm;
    logic [3:0]  ea;
    logic [3:0]  eb;
    logic [2:0]  es;
    logic [7:0]  et;
  } vec_t;
  vec_t vecs [7];

  guess_number_core #(.DIGITS(4), .MAX_TRIES(10), .TICK_DIV(TICK), .LFSR_SEED(SEED)) u0 (
    .clk(clk), .reset(reset_v[0]), .plus(plus_n[0]), .subtract(sub_n[0]), .sure(sure_n[0]),
`ifdef GUESS_NUMBER_PEEK_EN
    .force_ans(force_v[0]), .answer(ans_o[0]),
`endif
    .guess(g_o[0]), .cursor(cur_o[0]), .score_a(sa_o[0]), .score_b(sb_o[0]),
    .tries(tr_o[0]), .state(st[0]));

  guess_number_core #(.DIGITS(4), .MAX_TRIES(2), .TICK_DIV(TICK), .LFSR_SEED(SEED)) u1 (
    .clk(clk), .reset(reset_v[1]), .plus(plus_n[1]), .subtract(sub_n[1]), .sure(sure_n[1]),
`ifdef GUESS_NUMBER_PEEK_EN
    .force_ans(force_v[1]), .answer(ans_o[1]),
`endif
    .guess(g_o[1]), .cursor(cur_o[1]), .score_a(sa_o[1]), .score_b(sb_o[1]),
    .tries(tr_o[1]), .state(st[1]));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] lfsr_nxt(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  // Expected answer and GEN duration from the LFSR value seen in the first GEN cycle.
  function automatic void predict(input logic [15:0] l0, output logic [15:0] ans, output int len);
    logic [15:0] l;
    logic [9:0]  used;
    logic [3:0]  c;
    int          cnt;
    l = l0; used = '0; cnt = 0; len = 0; ans = '0;
    while (cnt < 4 && len < 2000) begin
      c = l[3:0];
      len++;
      if (c <= 4'd9 && !used[c]) begin
        used[c] = 1'b1;
        ans[15-4*cnt -: 4] = c;
        cnt++;
      end
      l = lfsr_nxt(l);
    end
  endfunction

  function automatic logic [15:0] build(input logic [15:0] ans, input logic [15:0] perm);
    logic [15:0] r;
    logic [9:0]  used;
    logic [3:0]  p, other;
    used = '0; r = '0; other = 4'd0;
    for (int d = 0; d < 4; d++) used[ans[15-4*d -: 4]] = 1'b1;
    for (int v = 9; v >= 0; v--) if (!used[v]) other = 4'(v);
    for (int d = 0; d < 4; d++) begin
      p = perm[15-4*d -: 4];
      r[15-4*d -: 4] = (p == 4'hF) ? other : ans[15-4*int'(p) -: 4];
    end
    return r;
  endfunction

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance n clocks; mirrors the LFSR and checks every GEN phase against the prediction.
  task automatic step(input int n);
    logic [1:0] rs;
    for (int c = 0; c < n; c++) begin
      rs = reset_v;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        m_lfsr[k] = rs[k] ? SEED : lfsr_nxt(m_lfsr[k]);
        if (rs[k]) begin
          in_gen[k] = 1'b0;
        end else if (st[k] == S_GEN && !in_gen[k]) begin
          predict(m_lfsr[k], exp_ans[k], exp_len[k]);
          in_gen[k]  = 1'b1;
          gen_cnt[k] = 1;
        end else if (in_gen[k]) begin
          if (st[k] == S_GEN) begin
            gen_cnt[k]++;
          end else begin
            in_gen[k] = 1'b0;
            check("gen_exit_state", st[k], S_EDIT);
            check("gen_len", gen_cnt[k], exp_len[k]);
            check("gen_len_max", gen_cnt[k] <= 64, 1);
          end
        end
      end
    end
  endtask

  // driver tasks
  task automatic press(input int k, input int b);
    if (b == B_SURE) sure_n[k] = 1'b0;
    if (b == B_PLUS || b == B_BOTH) plus_n[k] = 1'b0;
    if (b == B_SUB  || b == B_BOTH) sub_n[k]  = 1'b0;
    step(TICK);
    sure_n[k] = 1'b1; plus_n[k] = 1'b1; sub_n[k] = 1'b1;
    step(TICK);
  endtask

  task automatic wait_state(input int k, input logic [2:0] s, input int bound, input string name);
    int n;
    n = 0;
    while (st[k] !== s && n < bound) begin
      step(1);
      n++;
    end
    check(name, st[k], s);
  endtask

  task automatic start_game(input int k);
    sure_n[k] = 1'b0;
    wait_state(k, S_GEN, 2 * TICK, "gen_start");
    sure_n[k] = 1'b1;
    wait_state(k, S_EDIT, 80, "gen_done");
    step(TICK);
    exp_guess[k] = 16'h1234;
`ifdef GUESS_NUMBER_PEEK_EN
    check("peek_answer", ans_o[k], exp_ans[k]);
`endif
  endtask

  task automatic enter_guess(input int k, input logic [15:0] tgt);
    int cur, t, delta;
    for (int d = 0; d < 4; d++) begin
      cur   = int'(exp_guess[k][15-4*d -: 4]);
      t     = int'(tgt[15-4*d -: 4]);
      delta = (t - cur + 10) % 10;
      if (delta <= 5) for (int n = 0; n < delta; n++) press(k, B_PLUS);
      else            for (int n = 0; n < 10 - delta; n++) press(k, B_SUB);
      if (d == 3) check("cursor_last", cur_o[k], 3);
      press(k, B_SURE);
    end
    exp_guess[k] = tgt;
  endtask

  task automatic do_reset(input int k, input int n);
    reset_v[k] = 1'b1;
    step(n);
    reset_v[k] = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset_v = 2'b11; plus_n = 2'b11; sub_n = 2'b11; sure_n = 2'b11; force_v = 2'b00;
    for (int k = 0; k < 2; k++) begin
      m_lfsr[k] = SEED; exp_ans[k] = '0; exp_guess[k] = 16'h1234;
      exp_len[k] = 0; gen_cnt[k] = 0; in_gen[k] = 1'b0;
    end
    vecs[0] = '{0, 16'h3210, 4'd0, 4'd4, S_EDIT, 8'd1};
    vecs[1] = '{0, 16'h0132, 4'd2, 4'd2, S_EDIT, 8'd2};
    vecs[2] = '{0, 16'hFF0F, 4'd0, 4'd1, S_EDIT, 8'd3};
    vecs[3] = '{0, 16'h0000, 4'd1, 4'd3, S_EDIT, 8'd4};
    vecs[4] = '{0, 16'h0123, 4'd4, 4'd0, S_WIN,  8'd5};
    vecs[5] = '{1, 16'hFFFF, 4'd0, 4'd0, S_EDIT, 8'd1};
    vecs[6] = '{1, 16'hFFFF, 4'd0, 4'd0, S_LOSE, 8'd2};

    // reset values
    step(3);
    reset_v = 2'b00;
    step(1);
    check("rst_guess", g_o[0], 16'h1234);
    check("rst_state", st[0], S_IDLE);
    check("rst_cursor", cur_o[0], 0);
    check("rst_tries", tr_o[0], 0);
    check("rst_score_a", sa_o[0], 0);
    check("rst_score_b", sb_o[0], 0);

`ifdef GUESS_NUMBER_PEEK_EN
    force_v[0] = 1'b1;
    step(1);
    force_v[0] = 1'b0;
    step(1);
    check("force_state", st[0], S_EDIT);
    check("force_answer", ans_o[0], 16'h1234);
    check("force_guess", g_o[0], 16'h1234);
    do_reset(0, 3);
`endif

    // edit and wrap on digit 0
    start_game(0);
    plus_n[0] = 1'b0;
    step(20);
    plus_n[0] = 1'b1;
    step(TICK);
    check("plus_held_once", g_o[0], 16'h2234);
    press(0, B_SUB);
    check("sub_1", g_o[0], 16'h1234);
    press(0, B_SUB);
    check("sub_0", g_o[0], 16'h0234);
    press(0, B_SUB);
    check("sub_wrap9", g_o[0], 16'h9234);
    press(0, B_BOTH);
    check("plus_sub_ignored", g_o[0], 16'h9234);
    check("edit_cursor", cur_o[0], 0);
    exp_guess[0] = 16'h9234;

    // scoring vectors on both instances
    start_game(1);
    for (int v = 0; v < 7; v++) begin
      int          k;
      logic [15:0] tgt;
      k   = vecs[v].k;
      tgt = build(exp_ans[k], vecs[v].perm);
      enter_guess(k, tgt);
      check("vec_guess", g_o[k], tgt);
      check("vec_score_a", sa_o[k], vecs[v].ea);
      check("vec_score_b", sb_o[k], vecs[v].eb);
      check("vec_state", st[k], vecs[v].es);
      check("vec_tries", tr_o[k], vecs[v].et);
      check("vec_cursor", cur_o[k], 0);
    end

    // WIN and LOSE ignore plus
    press(0, B_PLUS);
    check("win_plus_guess", g_o[0], exp_guess[0]);
    check("win_hold_state", st[0], S_WIN);
    press(1, B_PLUS);
    check("lose_plus_guess", g_o[1], exp_guess[1]);
    check("lose_hold_state", st[1], S_LOSE);
    check("lose_hold_tries", tr_o[1], 2);

    // new game from LOSE
    start_game(1);
    check("new_tries", tr_o[1], 0);
    check("new_guess", g_o[1], 16'h1234);
    check("new_score_a", sa_o[1], 0);
    check("new_score_b", sb_o[1], 0);

    // reset during GEN, with sure held through reset release
    sure_n[0] = 1'b0;
    wait_state(0, S_GEN, 2 * TICK, "gen_before_reset");
    reset_v[0] = 1'b1;
    step(1);
    check("rst_gen_state", st[0], S_IDLE);
    check("rst_gen_guess", g_o[0], 16'h1234);
    step(2);
    reset_v[0] = 1'b0;
    step(3 * TICK);
    check("held_sure_no_press", st[0], S_IDLE);
    sure_n[0] = 1'b1;
    step(TICK);
    check("released_still_idle", st[0], S_IDLE);
    start_game(0);

    // GEN correctness over many games at varied offsets from reset
    for (int g = 0; g < 200; g++) begin
      do_reset(0, 1);
      step($urandom_range(0, 40));
      start_game(0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
